// File: rtl/mdu32.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle under a start/busy/done handshake.
module mdu32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         stateQ, stateD;
    logic [CW-1:0]      cntQ, cntD;
    logic [2*WIDTH-1:0] accQ, accD;
    logic [WIDTH-1:0]   divisorQ, divisorD;
    logic               isDivQ, isDivD;
    logic               negResQ, negResD;
    logic               negRemQ, negRemD;
    logic               divZeroQ, divZeroD;
    logic [WIDTH-1:0]   hiQ, hiD;
    logic [WIDTH-1:0]   loQ, loD;

    logic               aNeg, bNeg, accept;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [WIDTH:0]     mulSum, remShift, remDiff;
    logic [2*WIDTH-1:0] mulNext, divNext, stepNext, prodFinal;
    logic [WIDTH-1:0]   quot, rem, quotFinal, remFinal;

    assign aNeg   = op[0] & a[WIDTH-1];
    assign bNeg   = op[0] & b[WIDTH-1];
    assign aMag   = aNeg ? (~a + 1'b1) : a;
    assign bMag   = bNeg ? (~b + 1'b1) : b;
    assign accept = start && (stateQ != BUSY);

    // The accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mulSum   = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, divisorQ} : '0);
    assign mulNext  = {mulSum, accQ[WIDTH-1:1]};
    assign remShift = accQ[2*WIDTH-1:WIDTH-1];
    assign remDiff  = remShift - {1'b0, divisorQ};
    assign divNext  = remDiff[WIDTH] ? {accQ[2*WIDTH-2:0], 1'b0}
                                     : {remDiff[WIDTH-1:0], accQ[WIDTH-2:0], 1'b1};
    assign stepNext = isDivQ ? divNext : mulNext;

    // A zero divisor naturally leaves the dividend magnitude as remainder; sign restore yields a.
    assign prodFinal = negResQ ? (~stepNext + 1'b1) : stepNext;
    assign quot      = stepNext[WIDTH-1:0];
    assign rem       = stepNext[2*WIDTH-1:WIDTH];
    assign quotFinal = divZeroQ ? {WIDTH{1'b1}} : (negResQ ? (~quot + 1'b1) : quot);
    assign remFinal  = negRemQ ? (~rem + 1'b1) : rem;

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        accD     = accQ;
        divisorD = divisorQ;
        isDivD   = isDivQ;
        negResD  = negResQ;
        negRemD  = negRemQ;
        divZeroD = divZeroQ;
        hiD      = hiQ;
        loD      = loQ;
        if (stateQ == BUSY) begin
            accD = stepNext;
            cntD = cntQ + 1'b1;
            if (cntQ == CW'(WIDTH - 1)) begin
                stateD = DONE;
                if (isDivQ) begin
                    hiD = remFinal;
                    loD = quotFinal;
                end else begin
                    hiD = prodFinal[2*WIDTH-1:WIDTH];
                    loD = prodFinal[WIDTH-1:0];
                end
            end
        end else if (accept) begin
            stateD   = BUSY;
            cntD     = '0;
            accD     = {{WIDTH{1'b0}}, aMag};
            divisorD = bMag;
            isDivD   = op[1];
            negResD  = aNeg ^ bNeg;
            negRemD  = aNeg;
            divZeroD = op[1] && (b == '0);
        end else if (stateQ == DONE) begin
            stateD = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= IDLE;
            cntQ     <= '0;
            accQ     <= '0;
            divisorQ <= '0;
            isDivQ   <= 1'b0;
            negResQ  <= 1'b0;
            negRemQ  <= 1'b0;
            divZeroQ <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            accQ     <= accD;
            divisorQ <= divisorD;
            isDivQ   <= isDivD;
            negResQ  <= negResD;
            negRemQ  <= negRemD;
            divZeroQ <= divZeroD;
            hiQ      <= hiD;
            loQ      <= loD;
        end
    end

    assign busy = (stateQ == BUSY);
    assign done = (stateQ == DONE);
    assign hi   = hiQ;
    assign lo   = loQ;

endmodule

// File: tb/tb_mdu32.sv
// Scoreboard bench for mdu32: expected {hi,lo} pairs are queued at issue and
// compared whenever done pulses.
module tb_mdu32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int compareCount = 0;
    int failCount    = 0;
    int doneCount    = 0;
    int expectedDone = 0;
    logic [63:0] expQ[$];

    mdu32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] modelResult(input logic [1:0] mop,
                                                input logic [31:0] ma,
                                                input logic [31:0] mb);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        res = '0;
        case (mop)
            2'd0: res = {32'b0, ma} * {32'b0, mb};
            2'd1: res = 64'(sa * sb);
            2'd2: res = (mb == 0) ? {ma, 32'hFFFFFFFF} : {ma % mb, ma / mb};
            default: begin
                if (mb == 0) begin
                    res = {ma, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Every done pulse must correspond to an outstanding issued operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            doneCount++;
            checkOutput("doneWithPending", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) checkOutput("result", {hi, lo}, expQ.pop_front());
        end
    end

    task automatic applyStimulus(input logic [1:0] sop, input logic [31:0] sa,
                                 input logic [31:0] sb, input logic [63:0] exp);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = sop;
        a     = sa;
        b     = sb;
        expQ.push_back(exp);
        expectedDone++;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busyCycles);
        lat = 0;
        busyCycles = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy) busyCycles++;
            if (done) break;
        end
        checkOutput("doneSeen", {63'b0, done}, 64'd1);
    endtask

    initial begin
        int lat, bc, doneBefore;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusyDone", {62'b0, busy, done}, 64'd0);
        checkOutput("resetHiLo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        applyStimulus(2'd0, 32'd7, 32'd6, {32'h0, 32'h0000002A});
        waitDone(lat, bc);
        checkOutput("mulLatency", 64'(lat), 64'd33);
        checkOutput("busyCycles", 64'(bc), 64'd32);

        applyStimulus(2'd1, 32'hFFFFFFFD, 32'd5, {32'hFFFFFFFF, 32'hFFFFFFF1});
        waitDone(lat, bc);
        applyStimulus(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
        waitDone(lat, bc);
        applyStimulus(2'd2, 32'd100, 32'd7, {32'd2, 32'd14});
        waitDone(lat, bc);
        checkOutput("divLatency", 64'(lat), 64'd33);
        applyStimulus(2'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        waitDone(lat, bc);
        applyStimulus(2'd3, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
        waitDone(lat, bc);
        applyStimulus(2'd2, 32'h1234, 32'd0, {32'h00001234, 32'hFFFFFFFF});
        waitDone(lat, bc);
        checkOutput("divZeroLatency", 64'(lat), 64'd33);
        applyStimulus(2'd3, 32'hFFFFFF00, 32'd0, {32'hFFFFFF00, 32'hFFFFFFFF});
        waitDone(lat, bc);

        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (i[0]) rb = rb >> $urandom_range(0, 30);
            applyStimulus(rop, ra, rb, modelResult(rop, ra, rb));
            waitDone(lat, bc);
        end

        // start stays high and operands churn while busy
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'd0;
        a     = 32'h00012345;
        b     = 32'h00000777;
        expQ.push_back(modelResult(2'd0, 32'h00012345, 32'h00000777));
        expectedDone++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        waitDone(lat, bc);
        checkOutput("heldStartLatency", 64'(lat), 64'd23);

        // back-to-back: next start lands on the DONE cycle
        applyStimulus(2'd2, 32'd1000, 32'd33, {32'd10, 32'd30});
        waitDone(lat, bc);
        start = 1'b1;
        op    = 2'd1;
        a     = 32'hFFFF0001;
        b     = 32'h00070003;
        expQ.push_back(modelResult(2'd1, 32'hFFFF0001, 32'h00070003));
        expectedDone++;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2bBusyNoDone", {62'b0, busy, done}, 64'd2);
        waitDone(lat, bc);
        checkOutput("b2bLatency", 64'(lat), 64'd33);

        // asynchronous reset partway through an operation
        applyStimulus(2'd0, 32'h0000FFFF, 32'h0000FFFF, modelResult(2'd0, 32'h0000FFFF, 32'h0000FFFF));
        repeat (9) @(posedge clk);
        #2;
        doneBefore = doneCount;
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusyDone", {62'b0, busy, done}, 64'd0);
        checkOutput("abortHiLo", {hi, lo}, 64'd0);
        void'(expQ.pop_back());
        expectedDone--;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        checkOutput("noDoneAfterAbort", 64'(doneCount), 64'(doneBefore));
        applyStimulus(2'd3, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2});
        waitDone(lat, bc);
        checkOutput("postResetLatency", 64'(lat), 64'd33);

        repeat (3) @(posedge clk);
        checkOutput("doneCount", 64'(doneCount), 64'(expectedDone));
        checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
